trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Machine-mode trap/return sequencer behind pipeline_controller.
//  Takes the prioritised exception, the level interrupt lines and mret.
//  Drains and flushes the pipe, updates the trap CSRs and issues one PC redirect to mtvec or mepc.
//  Owns mstatus.MIE/MPIE, mie, mip (read-only), mtvec, mepc, mcause and mtval.
// PARAMETERS
//  RESET_MTVEC  32'h0000_0100  mtvec value after reset (direct mode)
//  VECTORED_EN  1              1: mtvec.MODE=1 is legal (vectored interrupts); 0: MODE is forced to 0
// PORTS
//  clk_i               in   1   clock; all state changes on rising edge
//  rst_i               in   1   asynchronous, active-low reset
//  exception_valid_i   in   1   prioritised exception present this cycle
//  exception_cause_i   in   4   RISC-V exception code (0,2,3,4,6,11)
//  exception_pc_i      in   32  PC of the faulting instruction
//  exception_tval_i    in   32  faulting address, or 0
//  mret_i              in   1   mret has reached decode
//  resume_pc_i         in   32  PC of the oldest unretired instruction (mepc for interrupts)
//  irq_software_i      in   1   MSIP level
//  irq_timer_i         in   1   MTIP level
//  irq_external_i      in   1   MEIP level
//  pipe_busy_i         in   1   memory stage stalled or store outstanding
//  csr_wr_en_i         in   1   CSR write strobe
//  csr_addr_i          in   12  CSR address, read and write
//  csr_wdata_i         in   32  CSR write data
//  csr_rdata_o         out  32  combinational read of csr_addr_i
//  flush_all_o         out  1   flush fetch..memory stages
//  stall_fetch_o       out  1   hold fetch PC
//  redirect_valid_o    out  1   one-cycle PC redirect strobe
//  redirect_pc_o       out  32  redirect target
//  trap_busy_o         out  1   FSM not in IDLE
// BEHAVIOUR
//  Reset (async, rst_i=0)
//   - state=IDLE; all outputs 0.
//   - mtvec=RESET_MTVEC; all other owned CSRs = 0.
//  FSM states: IDLE -> DRAIN -> SAVE -> REDIRECT -> IDLE. Outputs decode from the registered state.
//  IDLE
//   - Accepted events, by priority: exception > mret > interrupt.
//   - Interrupt taken only if mstatus.MIE=1 and (mip & mie) is non-zero.
//   - Interrupt priority: MEI(11) > MSI(3) > MTI(7).
//   - Accepting an event latches kind, cause, epc and tval, then goes to DRAIN.
//   - Latched epc: exception_pc_i for exceptions, resume_pc_i for interrupts.
//   - Latched tval: exception_tval_i for exceptions, 0 otherwise.
//   - Losing interrupts are not cleared; they are levels and re-evaluated in the next IDLE.
//  DRAIN
//   - flush_all_o=1, stall_fetch_o=1.
//   - Stays while pipe_busy_i=1 (unbounded); moves to SAVE on the first cycle pipe_busy_i=0.
//  SAVE (1 cycle, stall_fetch_o=1)
//   - Trap: mepc={epc[31:1],1'b0}; mtval=tval; MPIE<=MIE; MIE<=0.
//   - Trap mcause: exception {1'b0,27'b0,code}; interrupt {1'b1,27'b0,code}.
//   - mret: MIE<=MPIE; MPIE<=1.
//  REDIRECT (1 cycle): redirect_valid_o=1, stall_fetch_o=0.
//   - redirect_pc_o for a trap: {mtvec[31:2],2'b00}.
//   - For an interrupt with mtvec.MODE=1: that base + 4*code.
//   - For mret: mepc.
//  Latency: event accepted in cycle N with pipe_busy_i=0 -> redirect_valid_o=1 in N+3.
//  Events arriving while not in IDLE are ignored.
//  CSR writes
//   - Honoured only in IDLE; dropped in any other state.
//   - mtvec[1] always 0. mtvec.MODE is forced to 0 if VECTORED_EN=0.
//   - mip is read-only: {20'b0,MEIP,3'b0,MTIP,3'b0,MSIP,3'b0}.
//   - mie implements only bits 3, 7 and 11. mstatus implements only MIE(3) and MPIE(7).
//  CSR read map: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x344 mip; any other address reads 0.
//  Reset asserted mid-sequence: FSM returns to IDLE at once, no redirect is issued, CSRs reset.
// TESTING
//  T1 ecall: exception_cause_i=11, exception_pc_i=0x200, pipe_busy_i=0 -> redirect 0x100 at N+3, mepc=0x200, mcause=11, MIE=0.
//  T2 drain: misaligned load (cause 4, tval 0x1003), pipe_busy_i held 5 cycles -> flush_all_o high 6 cycles, redirect at N+8, mtval=0x1003.
//  T3 vectored: mtvec=0x401 written, MIE=1, mie=0x888, irq_timer_i=irq_external_i=1 -> mcause=0x8000000B, redirect 0x42C.
//  T4 mret: MPIE=1, mepc=0x204, mret_i -> redirect 0x204, MIE=1, MPIE=1; a timer IRQ in the same cycle with MIE=1 is taken next, with mcause=0x80000007.
//  T5 masking/collision: MIE=0 with all IRQs high -> no trap; exception+mret together -> exception trap; CSR write to mtvec during DRAIN -> mtvec unchanged.
//  T6 reset: rst_i low during DRAIN -> all outputs 0 asynchronously, mtvec=0x100, no redirect after reset release.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode trap/return sequencer.
// Accepts one event (exception, mret or interrupt) in IDLE, drains and flushes the pipe,
// updates the trap CSRs, then issues a single PC redirect to mtvec or to mepc.
module trap_sequencer #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exception_valid_i,
    input  logic [3:0]  exception_cause_i,
    input  logic [31:0] exception_pc_i,
    input  logic [31:0] exception_tval_i,
    input  logic        mret_i,
    input  logic [31:0] resume_pc_i,
    input  logic        irq_software_i,
    input  logic        irq_timer_i,
    input  logic        irq_external_i,
    input  logic        pipe_busy_i,
    input  logic        csr_wr_en_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        flush_all_o,
    output logic        stall_fetch_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        trap_busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_SAVE,
        S_REDIRECT
    } state_t;

    typedef enum logic [1:0] {
        KIND_EXC,
        KIND_MRET,
        KIND_IRQ
    } kind_t;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    state_t state, state_next;

    // Latched event
    kind_t       ev_kind;
    logic [3:0]  ev_cause;
    logic [31:0] ev_epc;
    logic [31:0] ev_tval;

    // Trap CSRs
    logic        mstatus_mie, mstatus_mpie;
    logic        mie_msie, mie_mtie, mie_meie;
    logic [31:0] mtvec, mepc, mcause, mtval;

    logic [31:0] mip_value, mie_value, mstatus_value;
    logic [31:0] irq_ready;
    logic        irq_take;
    logic [3:0]  irq_code;
    logic        accept;
    logic        csr_wr;
    logic [31:0] trap_base;
    logic [31:0] redirect_target;

    assign mip_value     = {20'b0, irq_external_i, 3'b0, irq_timer_i, 3'b0, irq_software_i, 3'b0};
    assign mie_value     = {20'b0, mie_meie, 3'b0, mie_mtie, 3'b0, mie_msie, 3'b0};
    assign mstatus_value = {24'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
    assign irq_ready     = mip_value & mie_value;
    assign irq_take      = mstatus_mie && (|irq_ready);
    assign accept        = (state == S_IDLE) && (exception_valid_i || mret_i || irq_take);
    assign csr_wr        = csr_wr_en_i && (state == S_IDLE);
    assign trap_base     = {mtvec[31:2], 2'b00};

    // Fixed interrupt priority: external, then software, then timer.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        irq_code = 4'd7;
        if (irq_ready[11])     irq_code = 4'd11;
        else if (irq_ready[3]) irq_code = 4'd3;
    end

    // State register; an asynchronous reset abandons any sequence in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_IDLE;
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        else        state <= state_next;
    end

    // Next-state logic: IDLE -> DRAIN -> SAVE -> REDIRECT -> IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:     if (accept) state_next = S_DRAIN;
            S_DRAIN:    if (!pipe_busy_i) state_next = S_SAVE;
            S_SAVE:     state_next = S_REDIRECT;
            S_REDIRECT: state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Capture kind, cause, epc and tval of the event accepted in IDLE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ev_kind  <= KIND_EXC;
            ev_cause <= 4'd0;
            ev_epc   <= 32'd0;
            ev_tval  <= 32'd0;
        end else if (accept) begin
            if (exception_valid_i) begin
                ev_kind  <= KIND_EXC;
                ev_cause <= exception_cause_i;
                ev_epc   <= exception_pc_i;
                ev_tval  <= exception_tval_i;
            end else if (mret_i) begin
                ev_kind  <= KIND_MRET;
                ev_cause <= 4'd0;
                ev_epc   <= 32'd0;
                ev_tval  <= 32'd0;
            end else begin
                ev_kind  <= KIND_IRQ;
                ev_cause <= irq_code;
                ev_epc   <= resume_pc_i;
                ev_tval  <= 32'd0;
            end
        end
    end

    // CSR state: software writes in IDLE, trap/return updates in SAVE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_msie     <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mtvec        <= RESET_MTVEC;
            mepc         <= 32'd0;
            mcause       <= 32'd0;
            mtval        <= 32'd0;
        end else if (state == S_SAVE) begin
            if (ev_kind == KIND_MRET) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else begin
                mepc         <= {ev_epc[31:1], 1'b0};
                mtval        <= ev_tval;
                mcause       <= {(ev_kind == KIND_IRQ), 27'b0, ev_cause};
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end
        end else if (csr_wr) begin
            unique case (csr_addr_i)
                ADDR_MSTATUS: begin
                    mstatus_mie  <= csr_wdata_i[3];
                    mstatus_mpie <= csr_wdata_i[7];
                end
                ADDR_MIE: begin
                    mie_msie <= csr_wdata_i[3];
                    mie_mtie <= csr_wdata_i[7];
                    mie_meie <= csr_wdata_i[11];
                end
                ADDR_MTVEC:  mtvec  <= {csr_wdata_i[31:2], 1'b0, VECTORED_EN ? csr_wdata_i[0] : 1'b0};
                ADDR_MEPC:   mepc   <= {csr_wdata_i[31:1], 1'b0};
                ADDR_MCAUSE: mcause <= csr_wdata_i;
                ADDR_MTVAL:  mtval  <= csr_wdata_i;
                default: ;
            endcase
        end
    end

    // Redirect target: mepc for mret, vectored slot for interrupts in MODE=1, else the base.
    always_comb begin
        redirect_target = trap_base;
        if (ev_kind == KIND_MRET)
            redirect_target = mepc;
        else if (ev_kind == KIND_IRQ && mtvec[0])
            redirect_target = trap_base + {26'b0, ev_cause, 2'b00};
    end

    // Pipeline control outputs decoded from the registered state.
    always_comb begin
        flush_all_o      = (state == S_DRAIN);
        stall_fetch_o    = (state == S_DRAIN) || (state == S_SAVE);
        redirect_valid_o = (state == S_REDIRECT);
        redirect_pc_o    = (state == S_REDIRECT) ? redirect_target : 32'd0;
        trap_busy_o      = (state != S_IDLE);
    end

    // Combinational CSR read port.
    always_comb begin
        csr_rdata_o = 32'd0;
        unique case (csr_addr_i)
            ADDR_MSTATUS: csr_rdata_o = mstatus_value;
            ADDR_MIE:     csr_rdata_o = mie_value;
            ADDR_MTVEC:   csr_rdata_o = mtvec;
            ADDR_MEPC:    csr_rdata_o = mepc;
            ADDR_MCAUSE:  csr_rdata_o = mcause;
            ADDR_MTVAL:   csr_rdata_o = mtval;
            ADDR_MIP:     csr_rdata_o = mip_value;
            default:      csr_rdata_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: CSR access table plus hand sequences for traps, mret and reset.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exception_valid = 1'b0;
    logic [3:0]  exception_cause = 4'd0;
    logic [31:0] exception_pc = 32'd0;
    logic [31:0] exception_tval = 32'd0;
    logic        mret = 1'b0;
    logic [31:0] resume_pc = 32'd0;
    logic        irq_software = 1'b0;
    logic        irq_timer = 1'b0;
    logic        irq_external = 1'b0;
    logic        pipe_busy = 1'b0;
    logic        csr_wr_en = 1'b0;
    logic [11:0] csr_addr = 12'd0;
    logic [31:0] csr_wdata = 32'd0;
    logic [31:0] csr_rdata;
    logic        flush_all;
    logic        stall_fetch;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_busy;

    int tests = 0;
    int failed = 0;

    trap_sequencer #(
        .RESET_MTVEC(32'h0000_0100),
        .VECTORED_EN(1'b1)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .exception_valid_i(exception_valid),
        .exception_cause_i(exception_cause),
        .exception_pc_i   (exception_pc),
        .exception_tval_i (exception_tval),
        .mret_i           (mret),
        .resume_pc_i      (resume_pc),
        .irq_software_i   (irq_software),
        .irq_timer_i      (irq_timer),
        .irq_external_i   (irq_external),
        .pipe_busy_i      (pipe_busy),
        .csr_wr_en_i      (csr_wr_en),
        .csr_addr_i       (csr_addr),
        .csr_wdata_i      (csr_wdata),
        .csr_rdata_o      (csr_rdata),
        .flush_all_o      (flush_all),
        .stall_fetch_o    (stall_fetch),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .trap_busy_o      (trap_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [2:0]  irq;   // {external, timer, software}
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_addr  = addr;
        csr_wdata = data;
        csr_wr_en = 1'b1;
        step();
        csr_wr_en = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
        csr_addr = addr;
        #1;
        data = csr_rdata;
    endtask

    // Steps from the accepting cycle until redirect; reports latency, flush cycles and target.
    task automatic run_event(input int busy_cycles, output int lat, output int flushes, output logic [31:0] pc);
        lat = 0;
        flushes = 0;
        pc = 32'd0;
        pipe_busy = (busy_cycles > 0);
        for (int i = 0; i < 40; i++) begin
            step();
            lat++;
            if (lat == 1) begin
                exception_valid = 1'b0;
                mret = 1'b0;
            end
            if (lat > busy_cycles) pipe_busy = 1'b0;
            if (flush_all) flushes++;
            if (redirect_valid) begin
                pc = redirect_pc;
                return;
            end
        end
        tests++;
        failed++;
        $display("FAIL redirect_timeout: got no redirect within 40 cycles");
    endtask

    task automatic set_exception(input logic [3:0] cause, input logic [31:0] pc, input logic [31:0] tval);
        exception_valid = 1'b1;
        exception_cause = cause;
        exception_pc    = pc;
        exception_tval  = tval;
    endtask

    initial begin
        int          lat, flushes;
        logic [31:0] pc, rd;
        logic        seen;

        vecs[0]  = '{1'b0, 12'h305, 32'h0,         3'b000, 32'h0000_0100};
        vecs[1]  = '{1'b0, 12'h300, 32'h0,         3'b000, 32'h0000_0000};
        vecs[2]  = '{1'b0, 12'h344, 32'h0,         3'b111, 32'h0000_0888};
        vecs[3]  = '{1'b0, 12'h344, 32'h0,         3'b010, 32'h0000_0080};
        vecs[4]  = '{1'b1, 12'h304, 32'hFFFF_FFFF, 3'b000, 32'h0000_0888};
        vecs[5]  = '{1'b1, 12'h300, 32'hFFFF_FFFF, 3'b000, 32'h0000_0088};
        vecs[6]  = '{1'b1, 12'h300, 32'h0,         3'b000, 32'h0000_0000};
        vecs[7]  = '{1'b1, 12'h305, 32'hFFFF_FFFF, 3'b000, 32'hFFFF_FFFD};
        vecs[8]  = '{1'b1, 12'h305, 32'h0000_0100, 3'b000, 32'h0000_0100};
        vecs[9]  = '{1'b1, 12'h343, 32'h0000_1234, 3'b000, 32'h0000_1234};
        vecs[10] = '{1'b1, 12'h341, 32'h0000_0200, 3'b000, 32'h0000_0200};
        vecs[11] = '{1'b0, 12'h123, 32'h0,         3'b000, 32'h0000_0000};
        vecs[12] = '{1'b1, 12'h304, 32'h0,         3'b000, 32'h0000_0000};

        // Reset state
        #2;
        check("rst_flush", {31'b0, flush_all}, 32'd0);
        check("rst_stall", {31'b0, stall_fetch}, 32'd0);
        check("rst_redirect", {31'b0, redirect_valid}, 32'd0);
        check("rst_busy", {31'b0, trap_busy}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // CSR access table
        for (int i = 0; i < 13; i++) begin
            {irq_external, irq_timer, irq_software} = vecs[i].irq;
            if (vecs[i].wr) csr_write(vecs[i].addr, vecs[i].wdata);
            csr_read(vecs[i].addr, rd);
            check($sformatf("csr_vec%0d", i), rd, vecs[i].exp);
            step();
        end
        {irq_external, irq_timer, irq_software} = 3'b000;

        // T1 ecall
        csr_write(12'h300, 32'h8);
        set_exception(4'd11, 32'h200, 32'h0);
        run_event(0, lat, flushes, pc);
        check("t1_latency", lat, 3);
        check("t1_redirect_pc", pc, 32'h100);
        check("t1_stall_in_redirect", {31'b0, stall_fetch}, 32'd0);
        csr_read(12'h341, rd); check("t1_mepc", rd, 32'h200);
        csr_read(12'h342, rd); check("t1_mcause", rd, 32'd11);
        csr_read(12'h300, rd); check("t1_mstatus", rd, 32'h80);
        step();
        check("t1_idle", {31'b0, trap_busy}, 32'd0);

        // T2 misaligned load with a 5-cycle drain
        set_exception(4'd4, 32'h208, 32'h1003);
        run_event(5, lat, flushes, pc);
        check("t2_latency", lat, 8);
        check("t2_flush_cycles", flushes, 6);
        check("t2_redirect_pc", pc, 32'h100);
        csr_read(12'h343, rd); check("t2_mtval", rd, 32'h1003);
        csr_read(12'h342, rd); check("t2_mcause", rd, 32'd4);
        step();

        // T3 vectored external interrupt beats timer
        csr_write(12'h305, 32'h401);
        csr_write(12'h304, 32'h888);
        csr_write(12'h300, 32'h8);
        resume_pc = 32'h300;
        irq_timer = 1'b1;
        irq_external = 1'b1;
        run_event(0, lat, flushes, pc);
        check("t3_latency", lat, 3);
        check("t3_redirect_pc", pc, 32'h42C);
        csr_read(12'h342, rd); check("t3_mcause", rd, 32'h8000_000B);
        csr_read(12'h341, rd); check("t3_mepc", rd, 32'h300);
        csr_read(12'h343, rd); check("t3_mtval", rd, 32'h0);
        irq_timer = 1'b0;
        irq_external = 1'b0;
        step();

        // T4 mret with a simultaneous timer interrupt, taken afterwards
        csr_write(12'h305, 32'h100);
        csr_write(12'h304, 32'h80);
        csr_write(12'h341, 32'h204);
        csr_write(12'h300, 32'h88);
        resume_pc = 32'h208;
        mret = 1'b1;
        irq_timer = 1'b1;
        run_event(0, lat, flushes, pc);
        check("t4_mret_latency", lat, 3);
        check("t4_mret_pc", pc, 32'h204);
        csr_read(12'h300, rd); check("t4_mstatus_after_mret", rd, 32'h88);
        step();
        run_event(0, lat, flushes, pc);
        check("t4_irq_latency", lat, 3);
        check("t4_irq_pc", pc, 32'h100);
        csr_read(12'h342, rd); check("t4_mcause", rd, 32'h8000_0007);
        csr_read(12'h341, rd); check("t4_mepc", rd, 32'h208);
        irq_timer = 1'b0;
        step();

        // T5a interrupts masked by MIE=0 (mstatus now 0x80)
        csr_write(12'h304, 32'h888);
        {irq_external, irq_timer, irq_software} = 3'b111;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen = seen | trap_busy;
        end
        check("t5_masked_no_trap", {31'b0, seen}, 32'd0);
        {irq_external, irq_timer, irq_software} = 3'b000;

        // T5b exception wins over mret
        set_exception(4'd2, 32'h400, 32'h0);
        mret = 1'b1;
        run_event(0, lat, flushes, pc);
        check("t5_collision_pc", pc, 32'h100);
        csr_read(12'h342, rd); check("t5_collision_mcause", rd, 32'd2);
        csr_read(12'h341, rd); check("t5_collision_mepc", rd, 32'h400);
        step();

        // T5c CSR write and a new exception during DRAIN are both ignored
        set_exception(4'd0, 32'h500, 32'h0);
        pipe_busy = 1'b1;
        step();
        check("t5_in_drain", {31'b0, flush_all}, 32'd1);
        set_exception(4'd6, 32'h600, 32'h0);
        csr_write(12'h305, 32'h800);
        exception_valid = 1'b0;
        pipe_busy = 1'b0;
        step();
        step();
        check("t5_drain_redirect_valid", {31'b0, redirect_valid}, 32'd1);
        check("t5_drain_redirect_pc", redirect_pc, 32'h100);
        csr_read(12'h305, rd); check("t5_mtvec_unchanged", rd, 32'h100);
        csr_read(12'h342, rd); check("t5_first_event_kept", rd, 32'd0);
        step();

        // T6 reset asserted during DRAIN
        csr_write(12'h305, 32'h404);
        set_exception(4'd11, 32'h700, 32'h0);
        pipe_busy = 1'b1;
        step();
        check("t6_in_drain", {31'b0, flush_all}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_flush", {31'b0, flush_all}, 32'd0);
        check("t6_rst_stall", {31'b0, stall_fetch}, 32'd0);
        check("t6_rst_busy", {31'b0, trap_busy}, 32'd0);
        check("t6_rst_redirect_pc", redirect_pc, 32'd0);
        csr_read(12'h305, rd); check("t6_rst_mtvec", rd, 32'h100);
        exception_valid = 1'b0;
        pipe_busy = 1'b0;
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | redirect_valid | trap_busy;
        end
        check("t6_no_redirect_after_reset", {31'b0, seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
